// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory controller.
// Lane parity is only used when DMEM_PARITY_EN is defined.
package dmem_pkg;

  localparam int BYTE_W     = 8;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 256;

  typedef enum logic {
    INIT,
    READY
  } state_t;

  // Even parity: the stored bit makes the lane plus parity hold an even number of ones.
  function automatic logic lane_parity(input logic [BYTE_W-1:0] lane);
    return ^lane;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Reset-less storage array with per-lane write enables, one synchronous
// write port and one registered read port.
module dmem_array #(
  parameter int LANE_W = 8,
  parameter int NB     = 2,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic                   clk,
  input  logic [NB-1:0]          we,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic [NB*LANE_W-1:0]   wdata,
  input  logic                   re,
  input  logic [ADDR_W-1:0]      raddr,
  output logic [NB*LANE_W-1:0]   rdata
);

  logic [NB*LANE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (we[i]) mem[waddr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data memory controller: zero-fill FSM, range check and one-cycle response.
// Optional per-lane parity storage and checking under DMEM_PARITY_EN.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  parameter  int ADDR_W = $clog2(DEPTH),
  localparam int NB     = DATA_W / BYTE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [NB-1:0]     req_be,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              par_err,
  input  logic              clear_req,
  output logic              init_busy
);

`ifdef DMEM_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int LANE_W = BYTE_W + PAR_W;
  localparam int MEM_W  = NB * LANE_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state, next_state;
  logic [ADDR_W-1:0] cnt;
  logic              accept, in_range;
  logic [NB-1:0]     arr_we;
  logic [ADDR_W-1:0] arr_waddr;
  logic [MEM_W-1:0]  arr_wdata, packed_wdata, arr_rdata;
  logic              arr_re;
  logic              rsp_valid_q, rsp_err_q, rsp_read_q;
  logic [DATA_W-1:0] read_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= INIT;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    init_busy  = 1'b0;
    case (state)
      INIT: begin
        init_busy = 1'b1;
        if (cnt == LAST) next_state = READY;
      end
      READY: begin
        req_ready = 1'b1;
        if (clear_req) next_state = INIT;
      end
      default: next_state = INIT;
    endcase
  end

  // Counter idles at 0 in READY so every fill, including one started by clear_req, begins at word 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            cnt <= '0;
    else if (state == INIT && cnt != LAST) cnt <= cnt + ADDR_W'(1);
    else                                   cnt <= '0;
  end

  assign accept   = req_valid && req_ready;
  assign in_range = 32'(req_addr) < 32'(DEPTH);

  always_comb begin
    packed_wdata = '0;
    for (int i = 0; i < NB; i++) begin
      packed_wdata[i*LANE_W +: BYTE_W] = req_wdata[i*BYTE_W +: BYTE_W];
`ifdef DMEM_PARITY_EN
      packed_wdata[i*LANE_W + BYTE_W] = lane_parity(req_wdata[i*BYTE_W +: BYTE_W]);
`endif
    end
  end

  always_comb begin
    arr_we    = '0;
    arr_waddr = req_addr;
    arr_wdata = packed_wdata;
    if (state == INIT) begin
      arr_we    = '1;
      arr_waddr = cnt;
      arr_wdata = '0;
    end else if (accept && req_we && in_range) begin
      arr_we = req_be;
    end
  end

  assign arr_re = accept && !req_we && in_range;

  dmem_array #(
    .LANE_W (LANE_W),
    .NB     (NB),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .re    (arr_re),
    .raddr (req_addr),
    .rdata (arr_rdata)
  );

  // Response flags are registered; read data comes from the array's own output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_read_q  <= 1'b0;
    end else begin
      rsp_valid_q <= accept;
      rsp_err_q   <= accept && !in_range;
      rsp_read_q  <= arr_re;
    end
  end

  always_comb begin
    read_data = '0;
    for (int i = 0; i < NB; i++) begin
      read_data[i*BYTE_W +: BYTE_W] = arr_rdata[i*LANE_W +: BYTE_W];
    end
  end

`ifdef DMEM_PARITY_EN
  logic read_par_bad;

  always_comb begin
    read_par_bad = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (arr_rdata[i*LANE_W + BYTE_W] != lane_parity(arr_rdata[i*LANE_W +: BYTE_W]))
        read_par_bad = 1'b1;
    end
  end

  assign par_err = rsp_read_q && read_par_bad;
`else
  assign par_err = 1'b0;
`endif

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_read_q ? read_data : '0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Randomized self-checking bench for dmem_ctrl (DEPTH=6, DATA_W=16) against a word-array model.
// The backdoor parity scenario is only built when DMEM_PARITY_EN is defined.
module tb_dmem_ctrl;

  localparam int DEPTH  = 6;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic [1:0]        req_be = '0;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              par_err;
  logic              clear_req = 1'b0;
  logic              init_busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] model [DEPTH];

  dmem_ctrl #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .par_err   (par_err),
    .clear_req (clear_req),
    .init_busy (init_busy)
  );

  always #5 clk = ~clk;

  // Reference: a plain word array; out-of-range requests touch nothing and read as zero.
  task automatic ref_req(input logic we, input logic [2:0] addr, input logic [15:0] wdata,
                         input logic [1:0] be, output logic [15:0] exp_d, output logic exp_e);
    exp_e = (int'(addr) >= DEPTH);
    exp_d = 16'h0000;
    if (!exp_e) begin
      if (we) begin
        if (be[0]) model[addr][7:0]  = wdata[7:0];
        if (be[1]) model[addr][15:8] = wdata[15:8];
      end else begin
        exp_d = model[addr];
      end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = 16'h0000;
  endtask

  // Presents one request for one edge and samples the response 1 ns after it.
  task automatic drive_req(input logic we, input logic [2:0] addr, input logic [15:0] wdata,
                           input logic [1:0] be, input logic clr,
                           output logic o_v, output logic [15:0] o_d, output logic o_e, output logic o_p);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    clear_req = clr;
    @(posedge clk);
    #1;
    o_v = rsp_valid;
    o_d = rsp_rdata;
    o_e = rsp_err;
    o_p = par_err;
    req_valid = 1'b0;
    clear_req = 1'b0;
  endtask

  // Counts edges until init_busy drops, bounded so a stuck fill cannot hang the run.
  task automatic wait_fill(output int edges);
    edges = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      edges++;
      if (!init_busy) break;
    end
  endtask

  task automatic test_reset();
    int edges;
    logic v, e, p, exp_e;
    logic [15:0] d, exp_d;
    #2 rst_n = 1'b0;
    #10;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got %b want 0", req_ready); end
    checks++; if (init_busy !== 1'b1) begin errors++; $display("[TB] FAIL reset_busy got %b want 1", init_busy); end
    checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 16'h0 || rsp_err !== 1'b0 || par_err !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_rsp got v=%b d=%h e=%b p=%b want all 0", rsp_valid, rsp_rdata, rsp_err, par_err);
    end
    @(negedge clk) rst_n = 1'b1;
    wait_fill(edges);
    checks++; if (edges != DEPTH) begin errors++; $display("[TB] FAIL reset_fill_edges got %0d want %0d", edges, DEPTH); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready_after got %b want 1", req_ready); end
    model_clear();
    for (int a = 0; a < DEPTH; a++) begin
      ref_req(1'b0, 3'(a), 16'h0, 2'b00, exp_d, exp_e);
      drive_req(1'b0, 3'(a), 16'h0, 2'b00, 1'b0, v, d, e, p);
      checks++; if (v !== 1'b1 || d !== exp_d || e !== exp_e || p !== 1'b0) begin
        errors++; $display("[TB] FAIL reset_read%0d got v=%b d=%h e=%b p=%b want v=1 d=%h e=%b p=0", a, v, d, e, p, exp_d, exp_e);
      end
    end
  endtask

  task automatic test_byte_lanes();
    logic v, e, p, exp_e;
    logic [15:0] d, exp_d;
    ref_req(1'b1, 3'd3, 16'hA5C3, 2'b11, exp_d, exp_e);
    drive_req(1'b1, 3'd3, 16'hA5C3, 2'b11, 1'b0, v, d, e, p);
    checks++; if (v !== 1'b1 || d !== 16'h0 || e !== 1'b0) begin
      errors++; $display("[TB] FAIL lanes_wr1 got v=%b d=%h e=%b want v=1 d=0000 e=0", v, d, e);
    end
    ref_req(1'b1, 3'd3, 16'h00FF, 2'b01, exp_d, exp_e);
    drive_req(1'b1, 3'd3, 16'h00FF, 2'b01, 1'b0, v, d, e, p);
    @(posedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 16'h0 || rsp_err !== 1'b0) begin
      errors++; $display("[TB] FAIL lanes_idle got v=%b d=%h e=%b want all 0", rsp_valid, rsp_rdata, rsp_err);
    end
    ref_req(1'b0, 3'd3, 16'h0, 2'b00, exp_d, exp_e);
    drive_req(1'b0, 3'd3, 16'h0, 2'b00, 1'b0, v, d, e, p);
    checks++; if (v !== 1'b1 || d !== 16'hA5FF || d !== exp_d) begin
      errors++; $display("[TB] FAIL lanes_rd got v=%b d=%h want v=1 d=a5ff", v, d);
    end
    ref_req(1'b1, 3'd3, 16'h1234, 2'b00, exp_d, exp_e);
    drive_req(1'b1, 3'd3, 16'h1234, 2'b00, 1'b0, v, d, e, p);
    checks++; if (v !== 1'b1) begin errors++; $display("[TB] FAIL lanes_be0_rsp got v=%b want 1", v); end
    ref_req(1'b0, 3'd3, 16'h0, 2'b00, exp_d, exp_e);
    drive_req(1'b0, 3'd3, 16'h0, 2'b00, 1'b0, v, d, e, p);
    checks++; if (d !== exp_d) begin errors++; $display("[TB] FAIL lanes_be0_rd got %h want %h", d, exp_d); end
  endtask

  task automatic test_back_to_back();
    logic v1, e1, p1, v2, e2, p2, exp_e;
    logic [15:0] d1, d2, exp_d, wd;
    wd = 16'($urandom);
    ref_req(1'b1, 3'd5, wd, 2'b11, exp_d, exp_e);
    drive_req(1'b1, 3'd5, wd, 2'b11, 1'b0, v1, d1, e1, p1);
    ref_req(1'b0, 3'd5, 16'h0, 2'b00, exp_d, exp_e);
    drive_req(1'b0, 3'd5, 16'h0, 2'b00, 1'b0, v2, d2, e2, p2);
    checks++; if (v1 !== 1'b1 || v2 !== 1'b1) begin
      errors++; $display("[TB] FAIL b2b_valid got %b%b want 11", v1, v2);
    end
    checks++; if (d2 !== exp_d) begin errors++; $display("[TB] FAIL b2b_data got %h want %h", d2, exp_d); end
  endtask

  task automatic test_out_of_range();
    logic v, e, p, exp_e;
    logic [15:0] d, exp_d;
    ref_req(1'b0, 3'd7, 16'h0, 2'b00, exp_d, exp_e);
    drive_req(1'b0, 3'd7, 16'h0, 2'b00, 1'b0, v, d, e, p);
    checks++; if (v !== 1'b1 || d !== 16'h0 || e !== 1'b1) begin
      errors++; $display("[TB] FAIL oor_rd7 got v=%b d=%h e=%b want v=1 d=0000 e=1", v, d, e);
    end
    ref_req(1'b1, 3'd6, 16'hBEEF, 2'b11, exp_d, exp_e);
    drive_req(1'b1, 3'd6, 16'hBEEF, 2'b11, 1'b0, v, d, e, p);
    checks++; if (v !== 1'b1 || d !== 16'h0 || e !== 1'b1) begin
      errors++; $display("[TB] FAIL oor_wr6 got v=%b d=%h e=%b want v=1 d=0000 e=1", v, d, e);
    end
    ref_req(1'b0, 3'd0, 16'h0, 2'b00, exp_d, exp_e);
    drive_req(1'b0, 3'd0, 16'h0, 2'b00, 1'b0, v, d, e, p);
    checks++; if (d !== exp_d || e !== 1'b0) begin
      errors++; $display("[TB] FAIL oor_addr0 got d=%h e=%b want d=%h e=0", d, e, exp_d);
    end
  endtask

  task automatic test_random();
    logic v, e, p, exp_e, we;
    logic [15:0] d, exp_d, wd;
    logic [2:0] addr;
    logic [1:0] be;
    for (int n = 0; n < 60; n++) begin
      we   = 1'($urandom);
      addr = 3'($urandom_range(0, 7));
      wd   = 16'($urandom);
      be   = 2'($urandom);
      ref_req(we, addr, wd, be, exp_d, exp_e);
      drive_req(we, addr, wd, be, 1'b0, v, d, e, p);
      checks++; if (v !== 1'b1 || d !== exp_d || e !== exp_e || p !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rand%0d we=%b a=%0d got v=%b d=%h e=%b p=%b want v=1 d=%h e=%b p=0",
                 n, we, addr, v, d, e, p, exp_d, exp_e);
      end
    end
  endtask

  task automatic test_clear();
    int edges;
    logic v, e, p, exp_e;
    logic [15:0] d, exp_d;
    ref_req(1'b1, 3'd2, 16'h5A5A, 2'b11, exp_d, exp_e);
    drive_req(1'b1, 3'd2, 16'h5A5A, 2'b11, 1'b1, v, d, e, p);
    checks++; if (v !== 1'b1 || d !== 16'h0 || e !== 1'b0) begin
      errors++; $display("[TB] FAIL clear_wr_rsp got v=%b d=%h e=%b want v=1 d=0000 e=0", v, d, e);
    end
    checks++; if (init_busy !== 1'b1 || req_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL clear_enter got busy=%b ready=%b want busy=1 ready=0", init_busy, req_ready);
    end
    // A clear pulse during the fill must not lengthen it.
    @(posedge clk);
    #1 clear_req = 1'b1;
    @(posedge clk);
    #1 clear_req = 1'b0;
    wait_fill(edges);
    checks++; if (edges + 2 != DEPTH) begin
      errors++; $display("[TB] FAIL clear_fill_edges got %0d want %0d", edges + 2, DEPTH);
    end
    model_clear();
    for (int a = 0; a < DEPTH; a++) begin
      ref_req(1'b0, 3'(a), 16'h0, 2'b00, exp_d, exp_e);
      drive_req(1'b0, 3'(a), 16'h0, 2'b00, 1'b0, v, d, e, p);
      checks++; if (v !== 1'b1 || d !== exp_d) begin
        errors++; $display("[TB] FAIL clear_read%0d got v=%b d=%h want v=1 d=%h", a, v, d, exp_d);
      end
    end
  endtask

  task automatic test_reset_midop();
    int edges;
    logic v, e, p, exp_e;
    logic [15:0] d, exp_d, wd;
    for (int a = 0; a < DEPTH; a++) begin
      wd = 16'($urandom) | 16'h0101;
      ref_req(1'b1, 3'(a), wd, 2'b11, exp_d, exp_e);
      drive_req(1'b1, 3'(a), wd, 2'b11, 1'b0, v, d, e, p);
    end
    ref_req(1'b0, 3'd1, 16'h0, 2'b00, exp_d, exp_e);
    drive_req(1'b0, 3'd1, 16'h0, 2'b00, 1'b0, v, d, e, p);
    checks++; if (v !== 1'b1 || d !== exp_d) begin
      errors++; $display("[TB] FAIL midop_rd got v=%b d=%h want v=1 d=%h", v, d, exp_d);
    end
    rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 16'h0 || init_busy !== 1'b1) begin
      errors++; $display("[TB] FAIL midop_drop got v=%b d=%h busy=%b want v=0 d=0000 busy=1", rsp_valid, rsp_rdata, init_busy);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    wait_fill(edges);
    checks++; if (edges != DEPTH) begin
      errors++; $display("[TB] FAIL midfill_edges got %0d want %0d", edges, DEPTH);
    end
    model_clear();
    for (int a = 0; a < DEPTH; a++) begin
      ref_req(1'b0, 3'(a), 16'h0, 2'b00, exp_d, exp_e);
      drive_req(1'b0, 3'(a), 16'h0, 2'b00, 1'b0, v, d, e, p);
      checks++; if (d !== exp_d) begin
        errors++; $display("[TB] FAIL midfill_read%0d got %h want %h", a, d, exp_d);
      end
    end
  endtask

`ifdef DMEM_PARITY_EN
  task automatic test_parity();
    logic v, e, p, exp_e;
    logic [15:0] d, exp_d;
    ref_req(1'b1, 3'd2, 16'h1234, 2'b11, exp_d, exp_e);
    drive_req(1'b1, 3'd2, 16'h1234, 2'b11, 1'b0, v, d, e, p);
    @(negedge clk);
    dut.u_array.mem[2][0] = ~dut.u_array.mem[2][0];
    model[2][0] = ~model[2][0];
    ref_req(1'b0, 3'd2, 16'h0, 2'b00, exp_d, exp_e);
    drive_req(1'b0, 3'd2, 16'h0, 2'b00, 1'b0, v, d, e, p);
    checks++; if (d !== exp_d || p !== 1'b1) begin
      errors++; $display("[TB] FAIL parity_flip got d=%h p=%b want d=%h p=1", d, p, exp_d);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_byte_lanes();
    test_back_to_back();
    test_out_of_range();
    test_random();
    test_clear();
    test_reset_midop();
`ifdef DMEM_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
